// File: rtl/mem_arbiter.sv
// Shares one memory port between the IFU and the LSU, one transaction at a
// time (IDLE -> BUSY -> RESP), with a watchdog that turns a hung access into an error response.
module mem_arbiter #(
  parameter int unsigned            ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0]   BASE_ADDR = ISA_WIDTH'(32'h8000_0000),
  parameter int unsigned            TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [ISA_WIDTH-1:0] ifu_addr,
  output logic                 ifu_resp_valid,
  output logic                 ifu_resp_err,
  output logic [ISA_WIDTH-1:0] ifu_rdata,
  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic                 lsu_wen,
  input  logic [ISA_WIDTH-1:0] lsu_addr,
  input  logic [ISA_WIDTH-1:0] lsu_wdata,
  output logic                 lsu_resp_valid,
  output logic                 lsu_resp_err,
  output logic [ISA_WIDTH-1:0] lsu_rdata,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [ISA_WIDTH-1:0] mem_addr,
  output logic [ISA_WIDTH-1:0] mem_w,
  input  logic [ISA_WIDTH-1:0] mem_r,
  input  logic                 mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t             r_state;
  logic               r_owner_lsu;
  logic               r_wen;
  logic               r_last_lsu;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_idle;
  logic               w_grant_ifu;
  logic               w_grant_lsu;
  logic               w_timeout;
  logic               w_exit;
  logic [ISA_WIDTH-1:0] w_rdata;

  // Round-robin: on contention the requester that did not win last time goes.
  assign w_idle      = (r_state == S_IDLE);
  assign w_grant_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || r_last_lsu);
  assign w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  // An ack always beats a coinciding timeout.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_exit    = mem_ack || w_timeout;
  assign w_rdata   = (mem_ack && !r_wen) ? mem_r : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_owner_lsu    <= 1'b0;
      r_wen          <= 1'b0;
      r_last_lsu     <= 1'b1;
      r_cnt          <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      lsu_rdata      <= '0;
      mem_r_en       <= 1'b0;
      mem_w_en       <= 1'b0;
      mem_addr       <= BASE_ADDR;
      mem_w          <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_ifu) begin
            r_state     <= S_BUSY;
            r_owner_lsu <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_wen       <= 1'b0;
            mem_addr    <= ifu_addr;
            mem_r_en    <= 1'b1;
            mem_w_en    <= 1'b0;
            mem_w       <= '0;
          end else if (w_grant_lsu) begin
            r_state     <= S_BUSY;
            r_owner_lsu <= 1'b1;
            r_last_lsu  <= 1'b1;
            r_wen       <= lsu_wen;
            mem_addr    <= lsu_addr;
            mem_r_en    <= !lsu_wen;
            mem_w_en    <= lsu_wen;
            mem_w       <= lsu_wen ? lsu_wdata : '0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_exit) begin
            r_state  <= S_RESP;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            mem_addr <= BASE_ADDR;
            mem_w    <= '0;
            if (r_owner_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_err   <= !mem_ack;
              lsu_rdata      <= w_rdata;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_resp_err   <= !mem_ack;
              ifu_rdata      <= w_rdata;
            end
          end
        end
        S_RESP: begin
          r_state        <= S_IDLE;
          r_cnt          <= '0;
          ifu_resp_valid <= 1'b0;
          lsu_resp_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses are queued at acceptance
// and popped when a resp_valid pulse appears.
module tb_mem_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic        lsu;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_resp_valid;
  logic        lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_w;
  logic [31:0] mem_r;
  logic        mem_ack;

  int   total;
  int   bad;
  exp_t sb[$];

  mem_arbiter #(.ISA_WIDTH(32), .BASE_ADDR(BASE), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_w(mem_w),
    .mem_r(mem_r), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic lsu, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.lsu   = lsu;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Pop and compare on any response pulse; a pulse with nothing queued is a failure.
  task automatic check_resp();
    exp_t e;
    if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_resp observed=ifu:%b/lsu:%b expected=none", ifu_resp_valid, lsu_resp_valid);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_ifu_valid", 32'(ifu_resp_valid), 32'(!e.lsu));
        chk("resp_lsu_valid", 32'(lsu_resp_valid), 32'(e.lsu));
        chk("resp_err",   32'(e.lsu ? lsu_resp_err : ifu_resp_err), 32'(e.err));
        chk("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
      end
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    check_resp();
  endtask

  initial begin
    int n;
    logic exp_lsu;
    logic [31:0] data;
    total = 0;
    bad   = 0;
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    mem_r = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ifu_valid", 32'(ifu_resp_valid), 32'd0);
    chk("rst_lsu_valid", 32'(lsu_resp_valid), 32'd0);
    chk("rst_r_en", 32'(mem_r_en), 32'd0);
    chk("rst_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_mem_w", mem_w, 32'd0);
    chk("rst_ifu_rdata", ifu_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Single IFU read, ack in the second BUSY cycle
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    #1;
    chk("ifu1_ready", 32'(ifu_req_ready), 32'd1);
    chk("ifu1_lsu_ready", 32'(lsu_req_ready), 32'd0);
    push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
    tick();
    ifu_req_valid = 1'b0;
    chk("ifu1_r_en_c1", 32'(mem_r_en), 32'd1);
    chk("ifu1_w_en", 32'(mem_w_en), 32'd0);
    chk("ifu1_addr", mem_addr, 32'h8000_0004);
    mem_r = 32'hDEAD_BEEF;
    tick();
    chk("ifu1_r_en_c2", 32'(mem_r_en), 32'd1);
    chk("ifu1_valid_busy", 32'(ifu_resp_valid), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ifu1_r_en_off", 32'(mem_r_en), 32'd0);
    chk("ifu1_addr_base", mem_addr, BASE);
    tick();
    chk("ifu1_one_pulse", 32'(ifu_resp_valid), 32'd0);
    chk("ifu1_rdata_hold", ifu_rdata, 32'hDEAD_BEEF);

    // Ack while IDLE must be ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_r_en", 32'(mem_r_en), 32'd0);
    tick();

    // LSU store with immediate ack
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100; lsu_wdata = 32'h1234_5678;
    #1;
    chk("st_ready", 32'(lsu_req_ready), 32'd1);
    push_exp(1'b1, 1'b0, 32'd0);
    tick();
    lsu_req_valid = 1'b0;
    chk("st_w_en", 32'(mem_w_en), 32'd1);
    chk("st_r_en", 32'(mem_r_en), 32'd0);
    chk("st_mem_w", mem_w, 32'h1234_5678);
    chk("st_addr", mem_addr, 32'h8000_0100);
    mem_ack = 1'b1; mem_r = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("st_addr_base", mem_addr, BASE);
    chk("st_mem_w_clr", mem_w, 32'd0);
    tick();

    // Contention after a fresh reset: IFU, LSU, IFU, LSU
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_2000;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
    for (int k = 0; k < 4; k++) begin
      exp_lsu = (k % 2) == 1;
      data    = 32'h1111_0000 + 32'(k);
      #1;
      chk("cont_ifu_ready", 32'(ifu_req_ready), 32'(!exp_lsu));
      chk("cont_lsu_ready", 32'(lsu_req_ready), 32'(exp_lsu));
      push_exp(exp_lsu, 1'b0, data);
      tick();
      chk("cont_addr", mem_addr, exp_lsu ? 32'h8000_3000 : 32'h8000_2000);
      mem_ack = 1'b1; mem_r = data;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("resp_no_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();

    // Timeout: LSU load never acked
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200; mem_r = 32'hAAAA_AAAA;
    #1;
    chk("to_ready", 32'(lsu_req_ready), 32'd1);
    push_exp(1'b1, 1'b1, 32'd0);
    tick();
    lsu_req_valid = 1'b0;
    n = 0;
    while (mem_r_en === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("to_busy_cycles", 32'(n), 32'd16);
    tick();

    // IFU served normally after the timeout
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    #1;
    chk("post_to_ready", 32'(ifu_req_ready), 32'd1);
    push_exp(1'b0, 1'b0, 32'h0BAD_F00D);
    tick();
    ifu_req_valid = 1'b0;
    mem_ack = 1'b1; mem_r = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    tick();

    // Ack in the last allowed BUSY cycle wins over the timeout
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0300;
    push_exp(1'b1, 1'b0, 32'hCAFE_F00D);
    tick();
    lsu_req_valid = 1'b0;
    repeat (15) tick();
    chk("tie_still_busy", 32'(mem_r_en), 32'd1);
    mem_ack = 1'b1; mem_r = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    tick();

    // Reset in the middle of BUSY abandons the access
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    chk("mid_busy_r_en", 32'(mem_r_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_r_en", 32'(mem_r_en), 32'd0);
    chk("mid_rst_addr", mem_addr, BASE);
    chk("mid_rst_ifu_rdata", ifu_rdata, 32'd0);
    chk("mid_rst_lsu_rdata", lsu_rdata, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    mem_ack = 1'b1; mem_r = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();
    chk("late_ack_r_en", 32'(mem_r_en), 32'd0);
    ifu_req_valid = 1'b1;
    #1;
    chk("after_rst_ready", 32'(ifu_req_ready), 32'd1);
    ifu_req_valid = 1'b0;
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port between the instruction fetch unit (IFU) and the load/store path (LSU).
- Sequences one memory transaction at a time: req handshake -> memory access -> completion ack -> response pulse.
- Drives the memory's mem_r_en, mem_w_en, mem_addr and mem_w signals; the LSU side takes the address, write data and enables produced by the execute stage.
- Includes a watchdog that converts a hung access into an error response.

Parameters:
ISA_WIDTH, 32, data and address width
BASE_ADDR, 32'h8000_0000, mem_addr value driven while no transaction is active
TIMEOUT, 16, max cycles in BUSY without mem_ack before an error response (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle when high with valid
ifu_addr  in  ISA_WIDTH  IFU fetch address
ifu_resp_valid  out  1  one-cycle IFU completion pulse
ifu_resp_err  out  1  qualifies ifu_resp_valid: access timed out
ifu_rdata  out  ISA_WIDTH  fetched word, valid with ifu_resp_valid
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted when high with valid
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  ISA_WIDTH  load/store address
lsu_wdata  in  ISA_WIDTH  store data
lsu_resp_valid  out  1  one-cycle LSU completion pulse (loads and stores)
lsu_resp_err  out  1  qualifies lsu_resp_valid: access timed out
lsu_rdata  out  ISA_WIDTH  load data; 0 for stores and errors
mem_r_en  out  1  memory read enable
mem_w_en  out  1  memory write enable
mem_addr  out  ISA_WIDTH  memory address
mem_w  out  ISA_WIDTH  memory write data
mem_r  in  ISA_WIDTH  memory read data, sampled on mem_ack
mem_ack  in  1  memory completion, single-cycle pulse

Behaviour:
- States: IDLE, BUSY, RESP. Reset state is IDLE.
- All outputs are registered except req_ready.
- Reset values:
  - resp_valid/err = 0; rdata = 0
  - mem_r_en = mem_w_en = 0; mem_addr = BASE_ADDR; mem_w = 0
  - last_grant = LSU; timeout counter = 0
- req_ready:
  - Combinational; high only in IDLE, and only for the requester selected by arbitration this cycle.
  - The other requester's ready is 0.
- Arbitration in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester NOT equal to last_grant wins (round-robin); last_grant updates on acceptance.
  - The first simultaneous request after reset therefore goes to the IFU.
- Acceptance (valid && ready) in IDLE:
  - Latch the owner, address, and (LSU) wen and wdata.
  - Next cycle, enter BUSY with mem_addr = latched address.
  - IFU, or LSU load: mem_r_en = 1, mem_w_en = 0.
  - LSU store: mem_w_en = 1, mem_r_en = 0, mem_w = wdata.
  - Minimum latency from acceptance to resp_valid is 2 cycles when mem_ack arrives in the first BUSY cycle.
- BUSY:
  - Enables, address and data are held stable until exit.
  - Counter increments each BUSY cycle.
  - mem_ack = 1: capture mem_r (0 for stores), drop the enables, restore mem_addr = BASE_ADDR and mem_w = 0, go to RESP.
  - No ack with counter == TIMEOUT-1: same exit, but rdata = 0 and err = 1.
  - If ack and timeout coincide, the ack wins (err = 0).
- RESP:
  - The owner's resp_valid = 1 for exactly one cycle with rdata/err; the non-owner's resp_valid stays 0.
  - Next state IDLE; counter clears. No new request is accepted in RESP.
- Outside RESP, resp_valid = 0; rdata/err hold their last values.
- mem_ack in IDLE or RESP is ignored.
- Requests are not queued. A requester holds valid and addr until it sees ready. Addr changes while not ready have no effect.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with reset values.
  - The in-flight access is abandoned: no resp_valid is issued, and a late mem_ack after release is ignored.
- Back-to-back: a request valid in the cycle after RESP is accepted in that IDLE cycle. Steady-state throughput is 1 transaction per 3 cycles with a 1-cycle memory.

Test Plan:
- Single IFU read: ifu_addr = 0x8000_0004, mem_ack one cycle after BUSY entry with mem_r = 0xDEADBEEF -> mem_r_en high 2 cycles at 0x8000_0004; ifu_resp_valid pulse, ifu_rdata = 0xDEADBEEF, err = 0; lsu_resp_valid stays 0.
- LSU store: lsu_wen = 1, addr = 0x8000_0100, wdata = 0x12345678, immediate ack -> mem_w_en = 1, mem_r_en = 0, mem_w = 0x12345678 in BUSY; lsu_resp_valid pulse with lsu_rdata = 0; mem_addr returns to 0x8000_0000.
- Contention: both valid continuously for 4 transactions after reset -> grant order IFU, LSU, IFU, LSU; the ready of the loser stays 0 in each IDLE cycle.
- Timeout: LSU load, mem_ack never asserted, TIMEOUT = 16 -> exactly 16 BUSY cycles, then lsu_resp_valid = 1, lsu_resp_err = 1, lsu_rdata = 0; a subsequent IFU request is served normally.
- Ack/timeout tie: mem_ack asserted in BUSY cycle 16 -> err = 0, rdata = mem_r.
- Reset mid-BUSY: drop rst low during BUSY, then release and pulse mem_ack -> outputs go to reset values asynchronously; no resp_valid ever pulses; state is IDLE, ready to accept.
